// File: rtl/cfu_initiator_li1.sv
// CFU initiator with level-1 valid/ready handshakes on both sides.
// One host command is accepted at a time. It is issued as a CFU request, and
// the response (or a timeout error) is returned to the host. A retire counter
// and a saturating error counter are kept.
// Every output is a flop or a captured operand register, so there is no
// combinational path from any input to any output.

module cfu_initiator_li1 #(
    parameter int CFU_FUNC_ID_W   = 1,
    parameter int CFU_REQ_DATA_W  = 32,
    parameter int CFU_RESP_DATA_W = 32,
    parameter int TIMEOUT         = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    // host command side
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CFU_FUNC_ID_W-1:0]   cmd_func_id,
    input  logic [CFU_REQ_DATA_W-1:0]  cmd_data0,
    input  logic [CFU_REQ_DATA_W-1:0]  cmd_data1,
    // host result side
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [CFU_RESP_DATA_W-1:0] res_data,
    output logic                       res_err,
    // CFU request side
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [CFU_FUNC_ID_W-1:0]   req_func_id,
    output logic [CFU_REQ_DATA_W-1:0]  req_data0,
    output logic [CFU_REQ_DATA_W-1:0]  req_data1,
    // CFU response side
    input  logic                       resp_valid,
    output logic                       resp_ready,
    input  logic [CFU_RESP_DATA_W-1:0] resp_data,
    // statistics
    output logic [15:0]                done_count,
    output logic [7:0]                 err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last timer value before the timeout fires. The timer starts at 0 on the
    // first REQ cycle, so TIMEOUT cycles in REQ/WAIT elapse before DONE.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t                       state_r;
    state_t                       state_next_s;

    logic [CFU_FUNC_ID_W-1:0]     func_id_r;
    logic [CFU_REQ_DATA_W-1:0]    data0_r;
    logic [CFU_REQ_DATA_W-1:0]    data1_r;
    logic [CFU_RESP_DATA_W-1:0]   res_data_r;
    logic                         res_err_r;
    logic [15:0]                  timer_r;
    logic [15:0]                  done_count_r;
    logic [7:0]                   err_count_r;

    logic                         cmd_ready_r;
    logic                         req_valid_r;
    logic                         res_valid_r;
    logic                         resp_ready_r;

    logic                         capture_s;
    logic                         retire_s;
    logic                         resp_fire_s;
    logic                         timer_expired_s;
    logic [15:0]                  timer_next_s;
    logic [CFU_RESP_DATA_W-1:0]   res_data_next_s;
    logic                         res_err_next_s;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic, plus the next values of the result and timer registers.
    always_comb begin
        state_next_s    = state_r;
        capture_s       = 1'b0;
        retire_s        = 1'b0;
        timer_next_s    = timer_r;
        res_data_next_s = res_data_r;
        res_err_next_s  = res_err_r;
        resp_fire_s     = resp_valid & resp_ready_r;
        timer_expired_s = (timer_r == TIMER_LAST);

        case (state_r)
            IDLE: begin
                // Any response seen here is a stray and is dropped.
                if (cmd_valid && cmd_ready_r) begin
                    state_next_s = REQ;
                    capture_s    = 1'b1;
                    timer_next_s = 16'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end

            REQ: begin
                // A response only counts together with the request handshake
                // (zero-latency CFU). Otherwise it is dropped.
                if (req_ready && resp_fire_s) begin
                    state_next_s    = DONE;
                    res_data_next_s = resp_data;
                    res_err_next_s  = 1'b0;
                end else if (timer_expired_s) begin
                    state_next_s    = DONE;
                    res_data_next_s = '0;
                    res_err_next_s  = 1'b1;
                end else if (req_ready) begin
                    state_next_s = WAIT;
                    timer_next_s = timer_r + 16'd1;
                end else begin
                    state_next_s = REQ;
                    timer_next_s = timer_r + 16'd1;
                end
            end

            WAIT: begin
                // A response on the timeout cycle takes priority over the error.
                if (resp_fire_s) begin
                    state_next_s    = DONE;
                    res_data_next_s = resp_data;
                    res_err_next_s  = 1'b0;
                end else if (timer_expired_s) begin
                    state_next_s    = DONE;
                    res_data_next_s = '0;
                    res_err_next_s  = 1'b1;
                end else begin
                    state_next_s = WAIT;
                    timer_next_s = timer_r + 16'd1;
                end
            end

            DONE: begin
                // Late responses that follow a timeout are consumed here.
                if (res_ready) begin
                    state_next_s = IDLE;
                    retire_s     = 1'b1;
                end else begin
                    state_next_s = DONE;
                end
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture. The operands stay stable for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_id_r <= '0;
            data0_r   <= '0;
            data1_r   <= '0;
        end else if (capture_s) begin
            func_id_r <= cmd_func_id;
            data0_r   <= cmd_data0;
            data1_r   <= cmd_data1;
        end
    end

    // Result data, error flag and timeout timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_r <= '0;
            res_err_r  <= 1'b0;
            timer_r    <= 16'd0;
        end else begin
            res_data_r <= res_data_next_s;
            res_err_r  <= res_err_next_s;
            timer_r    <= timer_next_s;
        end
    end

    // Completion counter (wraps) and timeout counter (saturates).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_count_r <= 16'd0;
            err_count_r  <= 8'd0;
        end else if (retire_s) begin
            done_count_r <= done_count_r + 16'd1;
            if (res_err_r) begin
                err_count_r <= sat_inc8(err_count_r);
            end
        end
    end

    // Handshake flags, registered from the next state so that each one lines
    // up with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_r  <= 1'b1;
            req_valid_r  <= 1'b0;
            res_valid_r  <= 1'b0;
            resp_ready_r <= 1'b0;
        end else begin
            cmd_ready_r  <= (state_next_s == IDLE);
            req_valid_r  <= (state_next_s == REQ);
            res_valid_r  <= (state_next_s == DONE);
            resp_ready_r <= 1'b1;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign req_valid   = req_valid_r;
    assign req_func_id = func_id_r;
    assign req_data0   = data0_r;
    assign req_data1   = data1_r;
    assign resp_ready  = resp_ready_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_err     = res_err_r;
    assign done_count  = done_count_r;
    assign err_count   = err_count_r;

endmodule
